// File: rtl/reg_file_sb_if.sv
// Bus bundle between decode / write-back and the integer register file with its
// pending-write scoreboard. The master modport is the pipeline side; the slave is the register file.
interface reg_file_sb_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
);
  logic [4:0]      i_rs1_index;
  logic [4:0]      i_rs2_index;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic [4:0]      i_rd_index;
  logic [XLEN-1:0] i_rd_data;
  logic            i_rd_we;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd;
  logic            o_issue_ready;
  logic            o_hazard;
  logic            i_flush;
  logic            o_sb_underflow;

  modport master (
    output i_rs1_index, i_rs2_index, i_rd_index, i_rd_data, i_rd_we,
           i_issue_valid, i_issue_rd, i_flush,
    input  o_rs1_data, o_rs2_data, o_issue_ready, o_hazard, o_sb_underflow
  );

  modport slave (
    input  i_rs1_index, i_rs2_index, i_rd_index, i_rd_data, i_rd_we,
           i_issue_valid, i_issue_rd, i_flush,
    output o_rs1_data, o_rs2_data, o_issue_ready, o_hazard, o_sb_underflow
  );
endinterface

// File: rtl/reg_file_sb.sv
// 32 x XLEN integer register file (x0 = 0) with per-register saturating pending-write counters.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding and retire-aware hazard.
module reg_file_sb #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  reg_file_sb_if.slave bus
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs_q [32];
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic             underflow_q;
  logic             underflow_d;

  logic             wrHit;
  logic [CNT_W-1:0] rdPend;
  logic             issueReady;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] rs1Pend;
  logic [CNT_W-1:0] rs2Pend;
  logic             busy1;
  logic             busy2;
  logic [XLEN-1:0]  rs1Data;
  logic [XLEN-1:0]  rs2Data;

  assign wrHit      = bus.i_rd_we && (bus.i_rd_index != 5'd0);
  assign rdPend     = pend_q[bus.i_rd_index];
  assign issueReady = (bus.i_issue_rd == 5'd0) || (pend_q[bus.i_issue_rd] != PEND_MAX);
  assign inc        = bus.i_issue_valid && issueReady && (bus.i_issue_rd != 5'd0) && !bus.i_flush;
  assign dec        = wrHit && (rdPend != '0);
  assign rs1Pend    = pend_q[bus.i_rs1_index];
  assign rs2Pend    = pend_q[bus.i_rs2_index];

  // A write-back with nothing outstanding is a bookkeeping error, except under flush,
  // where the tracking it would have retired was deliberately discarded.
  assign underflow_d = underflow_q || (wrHit && (rdPend == '0) && !bus.i_flush);

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      pend_d[r] = pend_q[r];
    end
    if (bus.i_flush) begin
      for (int r = 0; r < 32; r++) begin
        pend_d[r] = '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc && (bus.i_issue_rd == 5'(r)) && !(dec && (bus.i_rd_index == 5'(r)))) begin
          pend_d[r] = pend_q[r] + PEND_ONE;
        end else if (dec && (bus.i_rd_index == 5'(r)) && !(inc && (bus.i_issue_rd == 5'(r)))) begin
          pend_d[r] = pend_q[r] - PEND_ONE;
        end
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      if (wrHit) begin
        regs_q[bus.i_rd_index] <= bus.i_rd_data;
      end
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= pend_d[r];
      end
      underflow_q <= underflow_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic rs1Retire;
  logic rs2Retire;

  assign rs1Retire = dec && (bus.i_rd_index == bus.i_rs1_index);
  assign rs2Retire = dec && (bus.i_rd_index == bus.i_rs2_index);

  // The retiring write-back forwards its data, so a last outstanding write no longer stalls.
  assign busy1 = (bus.i_rs1_index != 5'd0) &&
                 ((rs1Pend > PEND_ONE) || ((rs1Pend == PEND_ONE) && !rs1Retire));
  assign busy2 = (bus.i_rs2_index != 5'd0) &&
                 ((rs2Pend > PEND_ONE) || ((rs2Pend == PEND_ONE) && !rs2Retire));

  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    if (bus.i_rs1_index != 5'd0) begin
      rs1Data = regs_q[bus.i_rs1_index];
      if (wrHit && (bus.i_rd_index == bus.i_rs1_index)) begin
        rs1Data = bus.i_rd_data;
      end
    end
    if (bus.i_rs2_index != 5'd0) begin
      rs2Data = regs_q[bus.i_rs2_index];
      if (wrHit && (bus.i_rd_index == bus.i_rs2_index)) begin
        rs2Data = bus.i_rd_data;
      end
    end
  end
`else
  assign busy1 = (bus.i_rs1_index != 5'd0) && (rs1Pend != '0);
  assign busy2 = (bus.i_rs2_index != 5'd0) && (rs2Pend != '0);

  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    if (bus.i_rs1_index != 5'd0) begin
      rs1Data = regs_q[bus.i_rs1_index];
    end
    if (bus.i_rs2_index != 5'd0) begin
      rs2Data = regs_q[bus.i_rs2_index];
    end
  end
`endif

  assign bus.o_rs1_data     = rs1Data;
  assign bus.o_rs2_data     = rs2Data;
  assign bus.o_issue_ready  = issueReady;
  assign bus.o_hazard       = busy1 || busy2;
  assign bus.o_sb_underflow = underflow_q;

endmodule
